reg_file_wb: RTL
================

# reg_file_wb

Architectural integer register file for the 5-stage RV32I pipeline, the write-side endpoint for the writeback stage's outputs (RegWriteW, RdW, ResultW). It commits writebacks on the clock edge and gives the decode stage two combinational read ports. Same-cycle writebacks are bypassed onto those ports, so the hazard unit needs no WB→ID forwarding path. After reset, a sequencer zeroes x1..x31 one register per cycle, which keeps the array inferable as LUT-RAM; `Ready` reports when that clear has finished.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural register count; x0 is hardwired to zero

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- RegWriteW  in  1  writeback enable from the writeback stage
- RdW  in  5  writeback destination register
- ResultW  in  XLEN  writeback data
- A1  in  5  read address, port 1 (rs1, decode stage)
- A2  in  5  read address, port 2 (rs2, decode stage)
- RD1  out  XLEN  read data, port 1
- RD2  out  XLEN  read data, port 2
- Ready  out  1  register, high once the post-reset clear has finished
- WrCount  out  32  register, count of committed writes to x1..x31

## Operation
- Two-state FSM: CLEAR and RUN.
- Reset edge (reset sampled high):
  - state←CLEAR, idx←1, Ready←0, WrCount←0.
  - Array contents are not changed on this edge.
- CLEAR:
  - Each edge writes mem[idx]←0 and increments idx.
  - On the edge where idx==31, mem[31]←0, state←RUN, Ready←1.
  - RegWriteW is ignored in CLEAR; writes are dropped and WrCount does not change.
  - RD1/RD2 read 0 in CLEAR.
- RUN:
  - A write commits on an edge when RegWriteW=1 and RdW≠0: mem[RdW]←ResultW, WrCount←WrCount+1.
  - WrCount wraps modulo 2^32.
  - RdW=0 with RegWriteW=1 is a no-op: no write, no count.
- Read ports, combinational, identical per port (shown for RD1):
  - A1==0 → 0.
  - Else RegWriteW && RdW==A1 → ResultW (write-through bypass).
  - Else → mem[A1].
- Both ports may address the same register, and both may hit the bypass in the same cycle.
- Reset asserted mid-CLEAR or mid-RUN: back to CLEAR at idx=1 and the full 31-cycle clear repeats.

## Timing
- Write latency: 1 edge. Bypass makes the written value visible on the read ports in the same cycle the writeback is presented.
- Read latency: 0 cycles (combinational from A1/A2, RegWriteW, RdW, ResultW).
- Clear duration: with E0 the last reset-high edge, edges E1..E31 clear x1..x31, and Ready is 1 after E31.
- Upstream must hold the pipeline stalled while Ready=0.
- Reset values:
  - Ready=0, WrCount=0.
  - RD1/RD2 are 0 during CLEAR regardless of array contents.

## Structure
- Shared package pipe_pkg:
  - XLEN and NREGS constants.
  - rf_state_t enum {RF_CLEAR, RF_RUN}.
  - REG_X0 constant (5'd0).
- One sub-module, rf_read_port: the x0 / bypass / array mux, instantiated twice.
- Array, FSM, idx counter and WrCount live in reg_file_wb.

## Test plan
- Reset clear: fill x1..x31 with 0xFFFFFFFF, pulse reset 1 cycle → Ready=0 for exactly 31 edges, then 1. Reading every register then returns 0.
- Basic write/read: RegWriteW=1, RdW=5, ResultW=0xDEADBEEF; next cycle A1=5 → RD1=0xDEADBEEF, WrCount=1.
- Bypass: mem[7]=0x11; in the same cycle RegWriteW=1, RdW=7, ResultW=0x22, A1=A2=7 → RD1=RD2=0x22 before the edge, and mem[7]=0x22 after it.
- x0 protection: RegWriteW=1, RdW=0, ResultW=0x1234, A1=0 → RD1=0 both during and after the edge, WrCount unchanged.
- Write during CLEAR: RegWriteW=1, RdW=3, ResultW=0x55 at cycle 10 after reset → after Ready rises, x3 reads 0 and WrCount=0.
- Reset mid-clear: reassert reset at cycle 15 of CLEAR → Ready rises exactly 31 edges after the second reset deasserts.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the RV32I pipeline register file
package pipe_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam logic [4:0] REG_X0 = 5'd0;
    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with x0 forcing and writeback bypass
//   i_run       high once the post-reset clear is done; reads are 0 before that
//   i_addr      read address
//   i_we/i_waddr/i_wdata  writeback presented this cycle
//   i_mem_data  array contents at i_addr
//   o_data      read data
module rf_read_port
    import pipe_pkg::*;
(
    input  logic            i_run,
    input  logic [4:0]      i_addr,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_mem_data,
    output logic [XLEN-1:0] o_data
);
    assign o_data = (!i_run || i_addr == REG_X0) ? '0 :
                    (i_we && i_waddr == i_addr)  ? i_wdata : i_mem_data;
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: RV32I register file with WB commit, two bypassed read ports and post-reset clear
//   clk, reset               clock, synchronous active-high reset
//   RegWriteW, RdW, ResultW  writeback from the WB stage
//   A1/RD1, A2/RD2           decode-stage read ports
//   Ready                    high once x1..x31 have been cleared
//   WrCount                  committed writes to x1..x31
module reg_file_wb
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      A1,
    input  logic [4:0]      A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            Ready,
    output logic [31:0]     WrCount
);
    logic [XLEN-1:0] r_mem [NREGS];
    rf_state_t       r_state;
    rf_state_t       w_state_next;
    logic [4:0]      r_idx;
    logic            r_ready;
    logic [31:0]     r_wr_count;
    logic            w_run;
    logic            w_commit;
    logic            w_we;
    logic [4:0]      w_waddr;
    logic [XLEN-1:0] w_wdata;

    assign w_run    = r_state == RF_RUN;
    assign w_commit = w_run && RegWriteW && RdW != REG_X0;
    // One shared write port (clear or commit) keeps the array LUT-RAM friendly;
    // the reset edge leaves the array untouched.
    assign w_we     = !reset && (!w_run || w_commit);
    assign w_waddr  = w_run ? RdW : r_idx;
    assign w_wdata  = w_run ? ResultW : '0;

    always_comb begin
        w_state_next = r_state;
        if (r_state == RF_CLEAR && r_idx == 5'd31)
            w_state_next = RF_RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RF_CLEAR;
            r_idx      <= 5'd1;
            r_ready    <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_run ? r_idx : r_idx + 5'd1;
            r_ready    <= r_ready || (r_state == RF_CLEAR && r_idx == 5'd31);
            r_wr_count <= w_commit ? r_wr_count + 32'd1 : r_wr_count;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    rf_read_port u_rd1 (
        .i_run(w_run), .i_addr(A1), .i_we(RegWriteW), .i_waddr(RdW),
        .i_wdata(ResultW), .i_mem_data(r_mem[A1]), .o_data(RD1)
    );

    rf_read_port u_rd2 (
        .i_run(w_run), .i_addr(A2), .i_we(RegWriteW), .i_waddr(RdW),
        .i_wdata(ResultW), .i_mem_data(r_mem[A2]), .o_data(RD2)
    );

    assign Ready   = r_ready;
    assign WrCount = r_wr_count;
endmodule
